// File: rtl/cmd_parser.sv
// Command word parser: pops headers and burst data from a show-ahead FIFO and issues register-bus writes/reads.
// Optional burst data timeout is enabled by defining CMD_TIMEOUT_EN.
module cmd_parser #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RD_WAIT_MAX    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fifo_q,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    output logic        reg_wr,
    output logic        reg_rd,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_rvalid,
    output logic [31:0] resp_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_BURST = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    localparam int RW_W = $clog2(RD_WAIT_MAX + 1);
    localparam logic [RW_W-1:0] RD_LAST = RW_W'(RD_WAIT_MAX - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'h01;
    endfunction

    state_t          state_r;
    logic            pop_s;
    logic            reg_wr_r;
    logic            reg_rd_r;
    logic [7:0]      reg_addr_r;
    logic [31:0]     reg_wdata_r;
    logic [31:0]     resp_data_r;
    logic            resp_valid_r;
    logic [7:0]      err_cnt_r;
    logic [7:0]      addr_r;
    logic [15:0]     len_r;
    logic [RW_W-1:0] wait_cnt_r;
    logic [7:0]      op_s;
    logic [7:0]      hdr_addr_s;
    logic [15:0]     imm_s;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt_r;
`endif

    assign op_s       = fifo_q[31:24];
    assign hdr_addr_s = fifo_q[23:16];
    assign imm_s      = fifo_q[15:0];

    // Pop the head word only in states that consume FIFO data, never when empty.
    always_comb begin
        if ((state_r == ST_IDLE || state_r == ST_BURST) && !fifo_rdempty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Main parser FSM with registered bus, response and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            reg_wr_r     <= 1'b0;
            reg_rd_r     <= 1'b0;
            reg_addr_r   <= 8'h00;
            reg_wdata_r  <= 32'h0000_0000;
            resp_data_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            err_cnt_r    <= 8'h00;
            addr_r       <= 8'h00;
            len_r        <= 16'h0000;
            wait_cnt_r   <= {RW_W{1'b0}};
`ifdef CMD_TIMEOUT_EN
            idle_cnt_r   <= {TO_W{1'b0}};
`endif
        end else begin
            reg_wr_r <= 1'b0;
            reg_rd_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        case (op_s)
                            OP_WRITE: begin
                                reg_wr_r    <= 1'b1;
                                reg_addr_r  <= hdr_addr_s;
                                reg_wdata_r <= {16'h0000, imm_s};
                            end
                            OP_BURST: begin
                                addr_r <= hdr_addr_s;
                                len_r  <= imm_s;
                                if (imm_s != 16'h0000) begin
                                    state_r <= ST_BURST;
                                end
                            end
                            OP_READ: begin
                                reg_rd_r   <= 1'b1;
                                reg_addr_r <= hdr_addr_s;
                                wait_cnt_r <= {RW_W{1'b0}};
                                state_r    <= ST_RD_WAIT;
                            end
                            default: begin
                                err_cnt_r <= sat_inc(err_cnt_r);
                            end
                        endcase
                    end
                end
                ST_BURST: begin
                    if (pop_s) begin
                        reg_wr_r    <= 1'b1;
                        reg_addr_r  <= addr_r;
                        reg_wdata_r <= fifo_q;
                        addr_r      <= addr_r + 8'h01;
                        len_r       <= len_r - 16'h0001;
                        if (len_r == 16'h0001) begin
                            state_r <= ST_IDLE;
                        end
                    end
`ifdef CMD_TIMEOUT_EN
                    // Starved burst: abandon the remaining length after too many empty cycles.
                    if (pop_s) begin
                        idle_cnt_r <= {TO_W{1'b0}};
                    end else if (idle_cnt_r == TO_LAST) begin
                        idle_cnt_r <= {TO_W{1'b0}};
                        len_r      <= 16'h0000;
                        err_cnt_r  <= sat_inc(err_cnt_r);
                        state_r    <= ST_IDLE;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + TO_W'(1);
                    end
`else
                    // Without the timeout a burst waits for its data indefinitely.
`endif
                end
                ST_RD_WAIT: begin
                    // A valid coinciding with the reg_rd strobe itself is not a real reply.
                    if (reg_rvalid && !reg_rd_r) begin
                        resp_data_r  <= reg_rdata;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else if (wait_cnt_r == RD_LAST) begin
                        resp_data_r  <= {16'hDEAD, 8'h00, reg_addr_r};
                        resp_valid_r <= 1'b1;
                        err_cnt_r    <= sat_inc(err_cnt_r);
                        state_r      <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + RW_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rdreq = pop_s;
    assign reg_wr     = reg_wr_r;
    assign reg_rd     = reg_rd_r;
    assign reg_addr   = reg_addr_r;
    assign reg_wdata  = reg_wdata_r;
    assign resp_data  = resp_data_r;
    assign resp_valid = resp_valid_r;
    assign busy       = (state_r != ST_IDLE);
    assign err_cnt    = err_cnt_r;

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Single-clock consumer sitting directly downstream of the command FIFO.
- Pops 32-bit command words from the FIFO's show-ahead read side and decodes them into register-bus writes, burst writes and register reads.
- Returns read data on a valid/ready response port and counts malformed commands.
- The FIFO read side is clocked by the same clk as this block.

Parameters:
- TIMEOUT_CYCLES, 1024: idle cycles tolerated while waiting for a burst data word. Used only with CMD_TIMEOUT_EN.
- RD_WAIT_MAX, 255: maximum cycles from reg_rd to reg_rvalid before the read is abandoned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_q  in  32  FIFO head word; valid whenever fifo_rdempty=0 (show-ahead).
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdreq  out  1  pop head word this cycle.
- reg_wr  out  1  one-cycle register write strobe.
- reg_rd  out  1  one-cycle register read strobe.
- reg_addr  out  8  register address for wr/rd.
- reg_wdata  out  32  write data, valid with reg_wr.
- reg_rdata  in  32  read data, sampled when reg_rvalid=1.
- reg_rvalid  in  1  read data valid.
- resp_data  out  32  response word.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- busy  out  1  state != IDLE.
- err_cnt  out  8  saturating count of errors.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: all outputs 0, state=IDLE, internal addr/len counters 0.
- Header format: [31:24] opcode, [23:16] addr, [15:0] imm/len.
- fifo_rdreq is combinational: (state==IDLE || state==BURST) && !fifo_rdempty. It is never asserted while fifo_rdempty=1.
- IDLE, when a word pops, decode:
  - 0x01 WRITE: next cycle reg_wr=1, reg_addr=addr, reg_wdata={16'h0,imm}. Stay IDLE.
  - 0x02 BURST: latch addr, len=imm. If len==0, stay IDLE with no strobes. Otherwise go to BURST.
  - 0x03 READ: next cycle reg_rd=1, reg_addr=addr. Go to RD_WAIT.
  - other: err_cnt+1 (saturate at 0xFF). Word discarded. Stay IDLE.
- BURST: each popped word produces reg_wr with reg_wdata=word and reg_addr=current addr on the next cycle. Then addr+1 (8-bit wrap 0xFF->0x00) and len-1. After the word that takes len to 0, go to IDLE.
- BURST words are data, never decoded as opcodes.
- Back-to-back pops allowed, giving one reg_wr per cycle at full throughput.
- RD_WAIT: fifo_rdreq=0.
  - On reg_rvalid: capture reg_rdata into resp_data, set resp_valid=1, go to RESP.
  - reg_rvalid asserted in the same cycle as reg_rd is ignored. Valid data is accepted from the cycle after reg_rd.
  - If RD_WAIT_MAX cycles elapse without reg_rvalid: err_cnt+1, resp_data=32'hDEAD_0000|addr, resp_valid=1, go to RESP.
- RESP: hold resp_valid and resp_data stable until resp_valid&&resp_ready. Clear resp_valid on that edge and go to IDLE. No FIFO pops while in RESP.
- Latency: header pop at cycle N gives its strobe at N+1. A READ response appears at the earliest 1 cycle after reg_rvalid.
- reg_wr and reg_rd are never asserted together. Each is high for exactly one cycle per event.
- Reset mid-operation (any state): immediate return to IDLE. Outputs clear. err_cnt is cleared. Remaining burst words in the FIFO are subsequently parsed as headers.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: in BURST, a counter increments on each cycle with fifo_rdempty=1 and resets on each pop. On reaching TIMEOUT_CYCLES: err_cnt+1, the remaining length is abandoned, and the block returns to IDLE.
- Not defined: BURST waits indefinitely for data words. The counter logic is absent.

Test Plan:
- Reset, then FIFO holds 0x0112_ABCD -> one cycle later reg_wr=1, reg_addr=0x12, reg_wdata=0x0000_ABCD. busy stays 0.
- Words 0x02FE_0003, 0x11, 0x22, 0x33 available back-to-back -> three consecutive reg_wr pulses: addr 0xFE/0x11, 0xFF/0x22, 0x00/0x33. Then IDLE.
- 0x0340_0000 with reg_rvalid 3 cycles after reg_rd (rdata 0xCAFEF00D), resp_ready held low 5 cycles -> resp_valid stays 1 with resp_data stable at 0xCAFEF00D until ready. Then IDLE.
- Opcode 0x7F word, then 0x0201_0000 -> err_cnt=1. Zero-length burst produces no reg_wr and the next header decodes normally.
- READ with reg_rvalid never asserted -> after RD_WAIT_MAX cycles resp_data=0xDEAD_0040, err_cnt increments.
- With CMD_TIMEOUT_EN: BURST len 4 with only 2 data words supplied -> after TIMEOUT_CYCLES empty cycles, state returns to IDLE and err_cnt+1. Assert rst mid-burst -> all outputs 0 on the same edge.
